// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU request arbiter and its FP adder.
package fpu_pkg;

  localparam int unsigned FpW = 32;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  // Leading-zero count of a 27-bit mantissa; 27 when the input is zero.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

endpackage

// File: rtl/fpu_add.sv
// Combinational IEEE-754 single add/sub: denormals flushed to zero, truncating rounding.
module fpu_add
  import fpu_pkg::*;
(
  input  logic [FpW-1:0] a_i,
  input  logic [FpW-1:0] b_i,
  input  logic           op_i,
  output logic [FpW-1:0] s_o,
  output logic           ov_o,
  output logic           un_o
);

  logic              sa, sb, sx, a_big;
  logic [7:0]        ea, eb, ex, ey, d;
  logic [23:0]       ma, mb, mx, my;
  logic [26:0]       my_sh, norm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] e_res;
  logic              a_nan, b_nan, a_inf, b_inf;

  always_comb begin
    sa    = a_i[31];
    sb    = b_i[31] ^ (op_i == OpSub);
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    ma    = (ea != 8'd0) ? {1'b1, a_i[22:0]} : 24'd0;
    mb    = (eb != 8'd0) ? {1'b1, b_i[22:0]} : 24'd0;
    a_nan = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
    b_nan = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
    a_inf = (ea == 8'hFF) && (a_i[22:0] == 23'd0);
    b_inf = (eb == 8'hFF) && (b_i[22:0] == 23'd0);

    // Order operands by magnitude so the difference is never negative.
    a_big = {ea, a_i[22:0]} >= {eb, b_i[22:0]};
    sx    = a_big ? sa : sb;
    ex    = a_big ? ea : eb;
    ey    = a_big ? eb : ea;
    mx    = a_big ? ma : mb;
    my    = a_big ? mb : ma;
    d     = ex - ey;
    my_sh = (d > 8'd26) ? 27'd0 : ({my, 3'b000} >> d);

    if (sa == sb) sum = {1'b0, mx, 3'b000} + {1'b0, my_sh};
    else          sum = {1'b0, mx, 3'b000} - {1'b0, my_sh};

    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = sum[27:1];
      e_res = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      e_res = $signed({2'b00, ex}) - $signed({5'b00000, lz});
    end

    s_o  = '0;
    ov_o = 1'b0;
    un_o = 1'b0;
    if (ea == 8'hFF || eb == 8'hFF) begin
      if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) s_o = 32'h7FC0_0000;
      else if (a_inf)                                        s_o = {sa, 8'hFF, 23'd0};
      else                                                   s_o = {sb, 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      // Exact cancellation of non-zero operands is flagged as underflow.
      un_o = (mx != 24'd0);
    end else if (e_res >= 10'sd255) begin
      s_o  = {sx, 8'hFF, 23'd0};
      ov_o = 1'b1;
    end else if (e_res <= 10'sd0) begin
      s_o  = {sx, 31'd0};
      un_o = 1'b1;
    end else begin
      s_o = {sx, e_res[7:0], norm[25:3]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [IdxW:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (idx >= (IdxW + 1)'(NUM_REQ)) idx = idx - (IdxW + 1)'(NUM_REQ);
      if (!found && req_i[idx[IdxW-1:0]]) begin
        gnt_o[idx[IdxW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FP adder among NUM_REQ requesters: IDLE grant, EXEC compute, RESP handshake.
module fpu_req_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ-1:0][FpW-1:0]   i_req_a,
  input  logic [NUM_REQ-1:0][FpW-1:0]   i_req_b,
  input  logic [NUM_REQ-1:0]            i_req_op,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  input  logic [NUM_REQ-1:0]            i_rsp_ready,
  output logic [FpW-1:0]                o_rsp_s,
  output logic                          o_rsp_ov,
  output logic                          o_rsp_un,
  output logic                          o_busy,
  output logic [CNT_W-1:0]              o_op_cnt,
  output logic [CNT_W-1:0]              o_ov_cnt
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d, gnt_idx_q, gnt_idx_d, gnt_idx;
  logic [FpW-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
  logic               op_q, op_d, ov_q, ov_d, un_q, un_d, busy_q, busy_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, gnt_oh;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d, ov_cnt_q, ov_cnt_d;
  logic [FpW-1:0]     fpu_s;
  logic               fpu_ov, fpu_un;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i(i_req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt_oh)
  );

  fpu_add u_fpu_add (
    .a_i (a_q),
    .b_i (b_q),
    .op_i(op_q),
    .s_o (fpu_s),
    .ov_o(fpu_ov),
    .un_o(fpu_un)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) gnt_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    s_d         = s_q;
    ov_d        = ov_q;
    un_d        = un_q;
    rsp_valid_d = rsp_valid_q;
    op_cnt_d    = op_cnt_q;
    ov_cnt_d    = ov_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req_valid) begin
          a_d       = i_req_a[gnt_idx];
          b_d       = i_req_b[gnt_idx];
          op_d      = i_req_op[gnt_idx];
          gnt_idx_d = gnt_idx;
          state_d   = StExec;
        end
      end
      StExec: begin
        s_d         = fpu_s;
        ov_d        = fpu_ov;
        un_d        = fpu_un;
        rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
        state_d     = StResp;
      end
      StResp: begin
        // Only the owner's ready bit can complete the handshake.
        if (i_rsp_ready[gnt_idx_q]) begin
          rsp_valid_d = '0;
          state_d     = StIdle;
          ptr_d       = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
          if (op_cnt_q != '1)         op_cnt_d = op_cnt_q + CNT_W'(1);
          if (ov_q && ov_cnt_q != '1) ov_cnt_d = ov_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OpAdd;
      s_q         <= '0;
      ov_q        <= 1'b0;
      un_q        <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      op_cnt_q    <= '0;
      ov_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      s_q         <= s_d;
      ov_q        <= ov_d;
      un_q        <= un_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      op_cnt_q    <= op_cnt_d;
      ov_cnt_q    <= ov_cnt_d;
    end
  end

  // Ready is combinational from valid, so it is also masked while reset is held.
  assign o_req_ready = (state_q == StIdle && i_rst_n) ? gnt_oh : '0;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_s     = s_q;
  assign o_rsp_ov    = ov_q;
  assign o_rsp_un    = un_q;
  assign o_busy      = busy_q;
  assign o_op_cnt    = op_cnt_q;
  assign o_ov_cnt    = ov_cnt_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: latency, FP results, round-robin, backpressure, reset.
module tb_fpu_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [N-1:0][31:0]  req_a, req_b;
  logic [31:0]         rsp_s;
  logic                rsp_ov, rsp_un, busy;
  logic [CW-1:0]       op_cnt, ov_cnt;
  int                  cmp_cnt = 0;
  int                  err_cnt = 0;

  always #5 clk = ~clk;

  fpu_req_arbiter #(
    .NUM_REQ(N),
    .CNT_W  (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_a    (req_a),
    .i_req_b    (req_b),
    .i_req_op   (req_op),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_s    (rsp_s),
    .o_rsp_ov   (rsp_ov),
    .o_rsp_un   (rsp_un),
    .o_busy     (busy),
    .o_op_cnt   (op_cnt),
    .o_ov_cnt   (ov_cnt)
  );

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    cmp_cnt++; if (req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    cmp_cnt++; if (rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL rst_rsp_valid: got %b want 0000", rsp_valid); end
    cmp_cnt++; if ({rsp_s, rsp_ov, rsp_un, busy} !== 35'd0) begin err_cnt++; $display("FAIL rst_outs: s=%h ov=%b un=%b busy=%b want zeros", rsp_s, rsp_ov, rsp_un, busy); end
    cmp_cnt++; if ({op_cnt, ov_cnt} !== 32'd0) begin err_cnt++; $display("FAIL rst_cnts: op=%0d ov=%0d want 0 0", op_cnt, ov_cnt); end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    @(negedge clk);
    req_valid = 4'b0001; req_a[0] = 32'h3F80_0000; req_b[0] = 32'h4000_0000; req_op[0] = 1'b0;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0001) begin err_cnt++; $display("FAIL add_ready: got %b want 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin err_cnt++; $display("FAIL add_exec: rsp_valid=%b busy=%b want 0000 1", rsp_valid, busy); end
    @(negedge clk);
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b0001) begin err_cnt++; $display("FAIL add_latency: rsp_valid=%b want 0001", rsp_valid); end
    cmp_cnt++; if ({rsp_s, rsp_ov, rsp_un} !== {32'h4040_0000, 2'b00}) begin err_cnt++; $display("FAIL add_result: s=%h ov=%b un=%b want 40400000 0 0", rsp_s, rsp_ov, rsp_un); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin err_cnt++; $display("FAIL add_done: rsp_valid=%b busy=%b want 0000 0", rsp_valid, busy); end
    cmp_cnt++; if (op_cnt !== 16'd1 || ov_cnt !== 16'd0) begin err_cnt++; $display("FAIL add_cnts: op=%0d ov=%0d want 1 0", op_cnt, ov_cnt); end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    req_valid = 4'b0010; req_a[1] = 32'h7F7F_FFFF; req_b[1] = 32'h7F7F_FFFF; req_op[1] = 1'b0;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0010) begin err_cnt++; $display("FAIL ov_ready: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b0010) begin err_cnt++; $display("FAIL ov_rsp_valid: got %b want 0010", rsp_valid); end
    cmp_cnt++; if ({rsp_s, rsp_ov} !== {32'h7F80_0000, 1'b1}) begin err_cnt++; $display("FAIL ov_result: s=%h ov=%b want 7f800000 1", rsp_s, rsp_ov); end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    cmp_cnt++; if (op_cnt !== 16'd2 || ov_cnt !== 16'd1) begin err_cnt++; $display("FAIL ov_cnts: op=%0d ov=%0d want 2 1", op_cnt, ov_cnt); end
  endtask

  task automatic test_underflow;
    @(negedge clk);
    req_valid = 4'b0100; req_a[2] = 32'h40A0_0000; req_b[2] = 32'h40A0_0000; req_op[2] = 1'b1;
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b0100) begin err_cnt++; $display("FAIL un_rsp_valid: got %b want 0100", rsp_valid); end
    cmp_cnt++; if ({rsp_s, rsp_ov, rsp_un} !== {32'h0000_0000, 2'b01}) begin err_cnt++; $display("FAIL un_result: s=%h ov=%b un=%b want 00000000 0 1", rsp_s, rsp_ov, rsp_un); end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    cmp_cnt++; if (op_cnt !== 16'd3 || ov_cnt !== 16'd1) begin err_cnt++; $display("FAIL un_cnts: op=%0d ov=%0d want 3 1", op_cnt, ov_cnt); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy, exp_rv;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      req_a[r] = 32'h3F80_0000; req_b[r] = 32'h3F80_0000; req_op[r] = 1'b0;
    end
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_rdy = (k % 3 == 0) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      exp_rv  = (k % 3 == 2) ? (4'b0001 << ((k / 3) % 4)) : 4'b0000;
      cmp_cnt++; if (req_ready !== exp_rdy || rsp_valid !== exp_rv) begin err_cnt++; $display("FAIL rr_cycle%0d: ready=%b rsp_valid=%b want %b %b", k, req_ready, rsp_valid, exp_rdy, exp_rv); end
      if (k % 3 == 2) begin
        cmp_cnt++; if (rsp_s !== 32'h4000_0000) begin err_cnt++; $display("FAIL rr_sum%0d: s=%h want 40000000", k, rsp_s); end
      end
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    cmp_cnt++; if (op_cnt !== 16'd5 || req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rr_end: op=%0d ready=%b want 5 0000", op_cnt, req_ready); end
  endtask

  // Grant pointer is 1 on entry; requester 3 is served, then the pointer wraps to 0.
  task automatic test_backpressure;
    @(negedge clk);
    req_valid = 4'b1000; req_a[3] = 32'h40A0_0000; req_b[3] = 32'h3F80_0000; req_op[3] = 1'b0;
    rsp_ready = 4'b0111;
    #1;
    cmp_cnt++; if (req_ready !== 4'b1000) begin err_cnt++; $display("FAIL bp_ready: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin err_cnt++; $display("FAIL bp_exec: ready=%b busy=%b want 0000 1", req_ready, busy); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      cmp_cnt++; if (rsp_valid !== 4'b1000 || rsp_s !== 32'h40C0_0000 || req_ready !== 4'b0000) begin err_cnt++; $display("FAIL bp_hold%0d: rsp_valid=%b s=%h ready=%b want 1000 40c00000 0000", k, rsp_valid, rsp_s, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 4'b1000;
    #1;
    cmp_cnt++; if (rsp_valid !== 4'b1000) begin err_cnt++; $display("FAIL bp_last: rsp_valid=%b want 1000", rsp_valid); end
    @(negedge clk);
    rsp_ready = 4'b0000;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL bp_wrap: ready=%b rsp_valid=%b want 0001 0000", req_ready, rsp_valid); end
    cmp_cnt++; if (op_cnt !== 16'd6) begin err_cnt++; $display("FAIL bp_cnt: op=%0d want 6", op_cnt); end
  endtask

  // Entered with requester 0 just accepted, so the first negedge here is in EXEC.
  task automatic test_reset_exec;
    @(negedge clk);
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    #1;
    cmp_cnt++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL rx_hs: ready=%b rsp_valid=%b want 0000 0000", req_ready, rsp_valid); end
    cmp_cnt++; if ({rsp_s, rsp_ov, rsp_un, busy} !== 35'd0) begin err_cnt++; $display("FAIL rx_outs: s=%h ov=%b un=%b busy=%b want zeros", rsp_s, rsp_ov, rsp_un, busy); end
    cmp_cnt++; if ({op_cnt, ov_cnt} !== 32'd0) begin err_cnt++; $display("FAIL rx_cnts: op=%0d ov=%0d want 0 0", op_cnt, ov_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      cmp_cnt++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin err_cnt++; $display("FAIL rx_after%0d: rsp_valid=%b busy=%b want 0000 0", k, rsp_valid, busy); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = '0;
    test_reset();
    test_add();
    test_overflow();
    test_underflow();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
